// File: rtl/hazard_unit.sv
// hazard_unit -- central pipeline controller for the five-stage RISC-V core.
//
// Purpose:
//   Drives the stall/flush controls of the F/D, D/E, E/M and M/W pipeline
//   registers and the Execute-stage operand-forwarding selects. Multi-cycle
//   data-memory accesses are sequenced by an IDLE/WAIT/ABORT state machine
//   with a timeout. A saturating counter tallies cycles spent with StallF=1.
//
// Configuration macro:
//   FORWARD_EN  defined   : M/W -> E forwarding, load-use stall only.
//               undefined : no forwarding (selects tied to 00); any pending
//                           E/M write to a Decode source stalls Decode.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   Rs1D, Rs2D                      Decode source registers
//   Rs1E, Rs2E, RdE                 Execute sources / destination
//   RdM, RdW                        Memory / WriteBack destinations
//   RegWriteE/M/W                   per-stage register-write enables
//   LoadE                           Execute instruction is a load
//   PCSrcE                          taken branch/jump resolved in Execute
//   MemReqM, MemReadyM              data-memory request / completion
//   StallF/D/E/M                    hold PC, F-D, D-E, E-M registers
//   FlushD/E/W                      bubble F-D, D-E, M-W registers
//   ForwardAE/BE                    00 regfile, 01 from W, 10 from M
//   MemErr                          sticky memory-timeout flag
//   StallCount                      saturating count of StallF cycles

module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic       mem_stall;
    logic       data_stall;
    logic [1:0] fwd_a, fwd_b;

    // ABORT masks the still-asserted request so the pipeline can drain.
    assign mem_stall = MemReqM & ~MemReadyM & (state != ABORT);

`ifdef FORWARD_EN
    // M has the younger value, so it beats W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)      return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        else                                            return 2'b00;
    endfunction

    assign fwd_a      = fwd_sel(Rs1E);
    assign fwd_b      = fwd_sel(Rs2E);
    // Only a load result is too late to forward into the next instruction.
    assign data_stall = LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    logic unused_sigs;
    assign unused_sigs = RegWriteE;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    // W needs no stall: the regfile is write-first.
    assign data_stall =
        (RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D))) |
        (RegWriteM & (RdM != 5'd0) & ((RdM == Rs1D) | (RdM == Rs2D)));

    logic unused_sigs;
    assign unused_sigs = ^{Rs1E, Rs2E, RdW, RegWriteW, LoadE};
`endif

    // Priority: memory stall > taken branch > data hazard. Everything is
    // forced inactive while reset is held.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                FlushW = (state == ABORT);
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (data_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: if (mem_stall) begin
                state_nxt    = WAIT;
                wait_cnt_nxt = WCNT_W'(1);
            end
            WAIT: begin
                // Ready on the limit cycle still completes normally.
                if (MemReadyM)                                state_nxt = IDLE;
                else if (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) state_nxt = ABORT;
                else                                          wait_cnt_nxt = wait_cnt + 1'b1;
            end
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            MemErr     <= 1'b0;
            StallCount <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == ABORT)
                MemErr <= 1'b1;
            if (StallF && StallCount != {CNT_W{1'b1}})
                StallCount <= StallCount + 1'b1;
        end
    end

endmodule
